// File: rtl/sram_bus_pkg.sv
// Shared types and constants for the SRAM-style bus responder.
package sram_bus_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, DONE, HOLD} sram_state_t;
    typedef logic [1:0] lane_mask_t;

    localparam lane_mask_t  LANE_UPPER = 2'b10;
    localparam lane_mask_t  LANE_LOWER = 2'b01;
    localparam int unsigned BUS_DATA_W = 16;
    localparam int unsigned BUS_ADDR_W = 20;

endpackage

// File: rtl/sram_byte_ram.sv
// Two-lane byte RAM: one shared write port (bus or preload) and a synchronous read port.
module sram_byte_ram
    import sram_bus_pkg::*;
#(
    parameter int unsigned DEPTH_W   = 10,
    parameter bit          INIT_ZERO = 1'b1
) (
    input  logic                  Clk,
    input  logic                  bus_we,
    input  lane_mask_t            bus_lanes,
    input  logic [DEPTH_W-1:0]    bus_addr,
    input  logic [BUS_DATA_W-1:0] bus_wdata,
    input  logic                  init_we,
    input  logic [DEPTH_W-1:0]    init_addr,
    input  logic [BUS_DATA_W-1:0] init_data,
    input  logic [DEPTH_W-1:0]    rd_addr,
    output logic [BUS_DATA_W-1:0] rd_data
);

    localparam int unsigned WORDS     = 2 ** DEPTH_W;
    localparam logic [7:0]  INIT_FILL = INIT_ZERO ? 8'h00 : 8'hxx;

    logic [7:0] mem_hi [WORDS] = '{default: INIT_FILL};
    logic [7:0] mem_lo [WORDS] = '{default: INIT_FILL};

    logic [DEPTH_W-1:0]    wr_addr;
    logic [BUS_DATA_W-1:0] wr_data;
    lane_mask_t            wr_lanes;

    // Preload and bus writes never coincide; preload still takes the port if they did.
    always_comb begin
        wr_addr  = bus_addr;
        wr_data  = bus_wdata;
        wr_lanes = bus_we ? bus_lanes : '0;
        if (init_we) begin
            wr_addr  = init_addr;
            wr_data  = init_data;
            wr_lanes = LANE_UPPER | LANE_LOWER;
        end
    end

    always_ff @(posedge Clk) begin
        if ((wr_lanes & LANE_UPPER) != '0) mem_hi[wr_addr] <= wr_data[15:8];
        if ((wr_lanes & LANE_LOWER) != '0) mem_lo[wr_addr] <= wr_data[7:0];
        rd_data <= {mem_hi[rd_addr], mem_lo[rd_addr]};
    end

endmodule

// File: rtl/sram_bus_responder.sv
// Target side of the async-SRAM-style CPU bus: strobe decode, wait-state FSM and
// Ready handshake in front of an on-chip byte-lane RAM with a preload port.
module sram_bus_responder
    import sram_bus_pkg::*;
#(
    parameter int unsigned DEPTH_W     = 10,
    parameter int unsigned WAIT_STATES = 2,
    parameter bit          INIT_ZERO   = 1'b1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  CE,
    input  logic                  OE,
    input  logic                  WE,
    input  logic                  UB,
    input  logic                  LB,
    input  logic [BUS_ADDR_W-1:0] A,
    input  logic [BUS_DATA_W-1:0] Data_out,
    output logic [BUS_DATA_W-1:0] Data_in,
    output logic                  Ready,
    input  logic                  init_we,
    input  logic [DEPTH_W-1:0]    init_addr,
    input  logic [BUS_DATA_W-1:0] init_data,
    output logic                  init_ack
);

    sram_state_t           state, state_n;
    logic [3:0]            cnt, cnt_n;
    logic                  latch, access;

    logic                  req_q, wr_q;
    lane_mask_t            lanes_q;
    logic [DEPTH_W-1:0]    a_q;
    logic [BUS_DATA_W-1:0] wdata_q;

    logic                  wr_r;
    lane_mask_t            lanes_r;
    logic [DEPTH_W-1:0]    addr_r;
    logic [BUS_DATA_W-1:0] wdata_r;

    logic [DEPTH_W-1:0]    rd_addr;
    logic [BUS_DATA_W-1:0] rd_data;
    logic                  preload;

    logic unused_addr_hi;
    assign unused_addr_hi = ^A[BUS_ADDR_W-1:DEPTH_W];

    // Bus strobes are registered once; this stage accounts for the first cycle of latency.
    always_ff @(posedge Clk) begin
        if (Reset) req_q <= 1'b0;
        else       req_q <= !CE && (!OE || !WE);
        wr_q    <= !WE;
        lanes_q <= {!UB, !LB};
        a_q     <= A[DEPTH_W-1:0];
        wdata_q <= Data_out;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        latch   = 1'b0;
        access  = 1'b0;
        case (state)
            IDLE: if (!init_we && req_q) begin
                state_n = WAIT;
                cnt_n   = 4'(WAIT_STATES);
                latch   = 1'b1;
            end
            WAIT: if (cnt == 4'd0) begin
                state_n = DONE;
                access  = 1'b1;
            end else begin
                cnt_n = cnt - 4'd1;
            end
            DONE: state_n = HOLD;
            HOLD: if (!req_q) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            Data_in  <= '0;
            init_ack <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            init_ack <= preload;
            if (access && !wr_r)
                Data_in <= {lanes_r[1] ? rd_data[15:8] : 8'h00,
                            lanes_r[0] ? rd_data[7:0]  : 8'h00};
        end
    end

    always_ff @(posedge Clk) begin
        if (latch) begin
            wr_r    <= wr_q;
            lanes_r <= lanes_q;
            addr_r  <= a_q;
            wdata_r <= wdata_q;
        end
    end

    assign Ready   = (state == DONE);
    assign preload = (state == IDLE) && init_we && !Reset;
    // Reading from a_q while idle lets the RAM output settle on the same edge that enters WAIT.
    assign rd_addr = (state == IDLE) ? a_q : addr_r;

    sram_byte_ram #(
        .DEPTH_W   (DEPTH_W),
        .INIT_ZERO (INIT_ZERO)
    ) u_ram (
        .Clk       (Clk),
        .bus_we    (access && wr_r && !Reset),
        .bus_lanes (lanes_r),
        .bus_addr  (addr_r),
        .bus_wdata (wdata_r),
        .init_we   (preload),
        .init_addr (init_addr),
        .init_data (init_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

endmodule

// File: tb/tb_sram_bus_responder.sv
// Self-checking bench for sram_bus_responder: directed table, hand sequences, random vs model.
module tb_sram_bus_responder;

    localparam int unsigned DW = 10;
    localparam int unsigned WS = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        CE, OE, WE, UB, LB;
    logic [19:0] A;
    logic [15:0] Data_out;
    logic [15:0] Data_in;
    logic        Ready;
    logic        init_we;
    logic [DW-1:0] init_addr;
    logic [15:0] init_data;
    logic        init_ack;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] model [1024];
    logic [15:0] last_rd;

    typedef struct {
        int          op;     // 0 read, 1 write, 2 OE and WE both low
        logic [19:0] addr;
        logic        ub;
        logic        lb;
        logic [15:0] wd;
        logic [15:0] exp;    // expected Data_in after the access
    } vec_t;
    vec_t vecs [12];

    sram_bus_responder #(
        .DEPTH_W     (DW),
        .WAIT_STATES (WS),
        .INIT_ZERO   (1'b1)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .CE        (CE),
        .OE        (OE),
        .WE        (WE),
        .UB        (UB),
        .LB        (LB),
        .A         (A),
        .Data_out  (Data_out),
        .Data_in   (Data_in),
        .Ready     (Ready),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data),
        .init_ack  (init_ack)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_step(input int op, input logic [19:0] addr, input logic ub,
                              input logic lb, input logic [15:0] wd);
        int unsigned i;
        i = int'(addr[DW-1:0]);
        if (op != 0) begin
            if (!ub) model[i][15:8] = wd[15:8];
            if (!lb) model[i][7:0]  = wd[7:0];
        end else begin
            last_rd = {ub ? 8'h00 : model[i][15:8], lb ? 8'h00 : model[i][7:0]};
        end
    endtask

    task automatic release_bus();
        CE = 1'b1; OE = 1'b1; WE = 1'b1; UB = 1'b1; LB = 1'b1;
    endtask

    task automatic preload(input logic [DW-1:0] addr, input logic [15:0] data);
        @(negedge Clk);
        init_we = 1'b1; init_addr = addr; init_data = data;
        @(posedge Clk); #1;
        check("init_ack_set", {31'd0, init_ack}, 32'd1);
        @(negedge Clk);
        init_we = 1'b0;
        @(posedge Clk); #1;
        check("init_ack_clear", {31'd0, init_ack}, 32'd0);
        model[int'(addr)] = data;
    endtask

    // One full bus access; returns Data_in sampled during the Ready cycle.
    task automatic do_access(input int op, input logic [19:0] addr, input logic ub,
                             input logic lb, input logic [15:0] wd, output logic [15:0] rd);
        int  edges;
        bit  seen;
        @(negedge Clk);
        A = addr; UB = ub; LB = lb; Data_out = wd; CE = 1'b0;
        OE = (op == 1) ? 1'b1 : 1'b0;
        WE = (op == 0) ? 1'b1 : 1'b0;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 40) begin
            @(posedge Clk); #1;
            edges++;
            if (Ready) seen = 1'b1;
        end
        check("ready_latency", edges, seen ? WS + 3 : 0);
        rd = Data_in;
        @(negedge Clk);
        release_bus();
        @(posedge Clk); #1;
        check("ready_one_cycle", {31'd0, Ready}, 32'd0);
        repeat (2) @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [15:0] rd;
        int          pulses;
        int          op;
        logic [19:0] addr;
        logic        ub, lb;
        logic [15:0] wd;

        for (int i = 0; i < 1024; i++) model[i] = 16'h0000;
        last_rd = 16'h0000;

        vecs[0]  = '{0, 20'h00005, 1'b0, 1'b0, 16'h0000, 16'h1261};
        vecs[1]  = '{1, 20'h00010, 1'b0, 1'b1, 16'hBEEF, 16'h1261};
        vecs[2]  = '{0, 20'h00010, 1'b0, 1'b0, 16'h0000, 16'hBE34};
        vecs[3]  = '{0, 20'h00010, 1'b1, 1'b0, 16'h0000, 16'h0034};
        vecs[4]  = '{2, 20'h00020, 1'b0, 1'b0, 16'hA5A5, 16'h0034};
        vecs[5]  = '{0, 20'h00020, 1'b0, 1'b0, 16'h0000, 16'hA5A5};
        vecs[6]  = '{0, 20'h00405, 1'b0, 1'b0, 16'h0000, 16'h1261};
        vecs[7]  = '{0, 20'h00005, 1'b1, 1'b1, 16'h0000, 16'h0000};
        vecs[8]  = '{1, 20'h00005, 1'b1, 1'b1, 16'hFFFF, 16'h0000};
        vecs[9]  = '{0, 20'h00005, 1'b0, 1'b0, 16'h0000, 16'h1261};
        vecs[10] = '{1, 20'h00005, 1'b1, 1'b0, 16'h00AB, 16'h1261};
        vecs[11] = '{0, 20'h00005, 1'b0, 1'b0, 16'h0000, 16'h12AB};

        Reset = 1'b1;
        release_bus();
        A = '0; Data_out = '0; init_we = 1'b0; init_addr = '0; init_data = '0;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_ready", {31'd0, Ready}, 32'd0);
        check("reset_data_in", {16'd0, Data_in}, 32'h0000);
        check("reset_init_ack", {31'd0, init_ack}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        preload(10'h005, 16'h1261);
        preload(10'h010, 16'h1234);

        for (int v = 0; v < 12; v++) begin
            do_access(vecs[v].op, vecs[v].addr, vecs[v].ub, vecs[v].lb, vecs[v].wd, rd);
            check($sformatf("table_%0d", v), {16'd0, rd}, {16'd0, vecs[v].exp});
            model_step(vecs[v].op, vecs[v].addr, vecs[v].ub, vecs[v].lb, vecs[v].wd);
        end

        // Strobes held low: one access per assertion.
        for (int rep = 0; rep < 2; rep++) begin
            @(negedge Clk);
            A = 20'h00040; Data_out = 16'h7777; UB = 1'b0; LB = 1'b0;
            CE = 1'b0; OE = 1'b1; WE = 1'b0;
            pulses = 0;
            for (int c = 0; c < 14; c++) begin
                @(posedge Clk); #1;
                if (Ready) pulses++;
            end
            check($sformatf("held_strobe_pulses_%0d", rep), pulses, 1);
            @(negedge Clk);
            release_bus();
            repeat (3) @(posedge Clk);
        end
        model_step(1, 20'h00040, 1'b0, 1'b0, 16'h7777);
        do_access(0, 20'h00040, 1'b0, 1'b0, 16'h0000, rd);
        model_step(0, 20'h00040, 1'b0, 1'b0, 16'h0000);
        check("held_write_readback", {16'd0, rd}, {16'd0, last_rd});

        // Reset during WAIT aborts a write.
        @(negedge Clk);
        A = 20'h00030; Data_out = 16'hDEAD; UB = 1'b0; LB = 1'b0;
        CE = 1'b0; OE = 1'b1; WE = 1'b0;
        pulses = 0;
        repeat (2) begin
            @(posedge Clk); #1;
            if (Ready) pulses++;
        end
        @(negedge Clk);
        Reset = 1'b1;
        release_bus();
        @(posedge Clk); #1;
        if (Ready) pulses++;
        @(negedge Clk);
        Reset = 1'b0;
        check("reset_abort_data_in", {16'd0, Data_in}, 32'h0000);
        repeat (8) begin
            @(posedge Clk); #1;
            if (Ready) pulses++;
        end
        check("reset_abort_no_ready", pulses, 0);
        last_rd = 16'h0000;
        do_access(0, 20'h00030, 1'b0, 1'b0, 16'h0000, rd);
        check("reset_abort_readback", {16'd0, rd}, 32'h0000);

        // init_we during HOLD is ignored.
        @(negedge Clk);
        A = 20'h00005; UB = 1'b0; LB = 1'b0; CE = 1'b0; OE = 1'b0; WE = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge Clk); #1;
            if (Ready) pulses++;
        end
        check("hold_read_ready", pulses, 1);
        @(negedge Clk);
        init_we = 1'b1; init_addr = 10'h005; init_data = 16'hFFFF;
        for (int c = 0; c < 2; c++) begin
            @(posedge Clk); #1;
            check("hold_init_ack", {31'd0, init_ack}, 32'd0);
        end
        @(negedge Clk);
        init_we = 1'b0;
        release_bus();
        repeat (3) @(posedge Clk);
        do_access(0, 20'h00005, 1'b0, 1'b0, 16'h0000, rd);
        model_step(0, 20'h00005, 1'b0, 1'b0, 16'h0000);
        check("hold_init_unchanged", {16'd0, rd}, {16'd0, last_rd});

        // Random traffic against the model.
        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(0, 4) == 0) begin
                preload(10'($urandom_range(0, 15)), 16'($urandom));
            end
            op   = int'($urandom_range(0, 2));
            addr = {10'($urandom), 6'd0, 4'($urandom_range(0, 15))};
            ub   = 1'($urandom);
            lb   = 1'($urandom);
            wd   = 16'($urandom);
            model_step(op, addr, ub, lb, wd);
            do_access(op, addr, ub, lb, wd, rd);
            check($sformatf("random_%0d_op%0d", r, op), {16'd0, rd}, {16'd0, last_rd});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
